// File: rtl/balsa_hs_pkg.sv
// Shared definitions for the Balsa four-phase handshake driver: FSM state
// encoding and the counter width helper.
package balsa_hs_pkg;

   typedef enum logic [2:0] {
      ST_RECOVER  = 3'd0,
      ST_IDLE     = 3'd1,
      ST_SETUP    = 3'd2,
      ST_GO_UP    = 3'd3,
      ST_PULL     = 3'd4,
      ST_PULL_RTZ = 3'd5,
      ST_GO_RTZ   = 3'd6,
      ST_RESP     = 3'd7
   } hs_state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/balsa_sync_bit.sv
// Multi-flop synchronizer for one asynchronous handshake wire; clears to 0.
module balsa_sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   localparam int N = (STAGES < 2) ? 2 : STAGES;

   logic [N-1:0] sr;

   always_ff @(posedge clk) begin
      if (!rst_n) sr <= '0;
      else        sr <= {sr[N-2:0], d};
   end

   assign q = sr[N-1];

endmodule

// File: rtl/balsa_bf_sync_driver.sv
// Clocked initiator for the Balsa_BF adder core: activates go, serves the i1/i2
// operand pulls with held data and pulls the sum on o.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// RECOVER     | all handshake outputs low, wait for every inbound wire low
// IDLE        | op_ready high, waiting for an operation
// SETUP       | operand data driven, bundling margin before go_0r
// GO_UP       | go_0r high, waiting for go_0a
// PULL        | o_0r high, waiting for o_0a, then capture o_0d
// PULL_RTZ    | o_0r low, waiting for o_0a low
// GO_RTZ      | go_0r low, waiting for go_0a low
// RESP        | res_valid high until res_ready
module balsa_bf_sync_driver
   import balsa_hs_pkg::*;
#(
   parameter int WIDTH          = 8,
   parameter int SYNC_STAGES    = 2,
   parameter int SETUP_CYCLES   = 1,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_err,
   output logic             go_0r,
   input  logic             go_0a,
   input  logic             i1_0r,
   output logic             i1_0a,
   output logic [WIDTH-1:0] i1_0d,
   input  logic             i2_0r,
   output logic             i2_0a,
   output logic [WIDTH-1:0] i2_0d,
   output logic             o_0r,
   input  logic             o_0a,
   input  logic [WIDTH-1:0] o_0d
);

   localparam int SYNC_N  = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam int CNT_MAX = (TIMEOUT_CYCLES > SETUP_CYCLES) ? TIMEOUT_CYCLES : SETUP_CYCLES;
   localparam int CW      = clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] TMO_LOAD   = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] SETUP_LOAD = CW'((SETUP_CYCLES > 0) ? SETUP_CYCLES - 1 : 0);

   logic go_0a_s, i1_0r_s, i2_0r_s, o_0a_s;

   balsa_sync_bit #(.STAGES(SYNC_N)) u_sync_go (.clk(clk), .rst_n(rst_n), .d(go_0a), .q(go_0a_s));
   balsa_sync_bit #(.STAGES(SYNC_N)) u_sync_i1 (.clk(clk), .rst_n(rst_n), .d(i1_0r), .q(i1_0r_s));
   balsa_sync_bit #(.STAGES(SYNC_N)) u_sync_i2 (.clk(clk), .rst_n(rst_n), .d(i2_0r), .q(i2_0r_s));
   balsa_sync_bit #(.STAGES(SYNC_N)) u_sync_o  (.clk(clk), .rst_n(rst_n), .d(o_0a),  .q(o_0a_s));

   hs_state_t       state, state_nxt;
   logic [CW-1:0]   cnt, cnt_load;
   logic            tc, timeout, accept, capture, hs_en;
   logic [SYNC_N-1:0] fill;
   logic            sync_ok;

   // The synchronizers read 0 straight out of reset; RECOVER must not trust
   // them until they have been refilled from the real wires.
   assign sync_ok = fill[SYNC_N-1];
   assign tc      = (cnt == '0);

   always_comb begin
      state_nxt = state;
      timeout   = 1'b0;
      accept    = 1'b0;
      capture   = 1'b0;
      case (state)
         ST_RECOVER:  if (sync_ok && !go_0a_s && !o_0a_s && !i1_0r_s && !i2_0r_s)
                         state_nxt = ST_IDLE;
         ST_IDLE:     if (op_valid && op_ready) begin
                         accept    = 1'b1;
                         state_nxt = ST_SETUP;
                      end
         ST_SETUP:    if (tc) state_nxt = ST_GO_UP;
         ST_GO_UP:    if (go_0a_s) state_nxt = ST_PULL;
                      else if (tc) timeout = 1'b1;
         ST_PULL:     if (o_0a_s) begin
                         capture   = 1'b1;
                         state_nxt = ST_PULL_RTZ;
                      end else if (tc) timeout = 1'b1;
         ST_PULL_RTZ: if (!o_0a_s) state_nxt = ST_GO_RTZ;
                      else if (tc) timeout = 1'b1;
         ST_GO_RTZ:   if (!go_0a_s) state_nxt = ST_RESP;
                      else if (tc) timeout = 1'b1;
         ST_RESP:     if (res_ready) state_nxt = res_err ? ST_RECOVER : ST_IDLE;
         default:     state_nxt = ST_RECOVER;
      endcase
      if (timeout) state_nxt = ST_RESP;

      case (state_nxt)
         ST_SETUP:                                         cnt_load = SETUP_LOAD;
         ST_RECOVER, ST_GO_UP, ST_PULL, ST_PULL_RTZ, ST_GO_RTZ: cnt_load = TMO_LOAD;
         default:                                          cnt_load = '0;
      endcase

      hs_en = (state_nxt == ST_SETUP) || (state_nxt == ST_GO_UP) || (state_nxt == ST_PULL) ||
              (state_nxt == ST_PULL_RTZ) || (state_nxt == ST_GO_RTZ);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_RECOVER;
         cnt       <= '0;
         fill      <= '0;
         op_ready  <= 1'b0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_err   <= 1'b0;
         go_0r     <= 1'b0;
         o_0r      <= 1'b0;
         i1_0a     <= 1'b0;
         i2_0a     <= 1'b0;
         i1_0d     <= '0;
         i2_0d     <= '0;
      end else begin
         state <= state_nxt;
         fill  <= {fill[SYNC_N-2:0], 1'b1};
         // A terminal count without a state change (RECOVER, IDLE, RESP) just reloads.
         if (state_nxt != state || tc) cnt <= cnt_load;
         else                          cnt <= cnt - 1'b1;

         // Outputs are registered from the next state so the core never sees decode glitches.
         op_ready  <= (state_nxt == ST_IDLE);
         res_valid <= (state_nxt == ST_RESP);
         go_0r     <= (state_nxt == ST_GO_UP) || (state_nxt == ST_PULL) || (state_nxt == ST_PULL_RTZ);
         o_0r      <= (state_nxt == ST_PULL);
         i1_0a     <= hs_en & i1_0r_s;
         i2_0a     <= hs_en & i2_0r_s;

         if (accept) begin
            i1_0d   <= op_a;
            i2_0d   <= op_b;
            res_err <= 1'b0;
         end
         if (capture) res_data <= o_0d;
         if (timeout) begin
            res_err  <= 1'b1;
            res_data <= '0;
         end
      end
   end

endmodule

// File: tb/tb_balsa_bf_sync_driver.sv
// Self-checking bench: behavioural Balsa_BF core with random async delays and
// a result scoreboard filled at operation accept.
module tb_balsa_bf_sync_driver;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         op_valid, op_ready;
   logic [W-1:0] op_a, op_b;
   logic         res_valid, res_ready, res_err;
   logic [W-1:0] res_data;
   logic         go_0r, go_0a, i1_0r, i1_0a, i2_0r, i2_0a, o_0r, o_0a;
   logic [W-1:0] i1_0d, i2_0d, o_0d;

   balsa_bf_sync_driver #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
      .go_0r(go_0r), .go_0a(go_0a),
      .i1_0r(i1_0r), .i1_0a(i1_0a), .i1_0d(i1_0d),
      .i2_0r(i2_0r), .i2_0a(i2_0a), .i2_0d(i2_0d),
      .o_0r(o_0r), .o_0a(o_0a), .o_0d(o_0d)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0, n_res = 0;
   int n_go_up = 0, n_o_up = 0, n_i1_up = 0, n_i2_up = 0;
   logic [W:0] sb[$];
   bit m_no_ack = 0, m_double = 0, m_hold = 0, m_release = 0;
   logic [W-1:0] cap_a, cap_b;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   always @(posedge go_0r) n_go_up++;
   always @(posedge o_0r)  n_o_up++;
   always @(posedge i1_0a) n_i1_up++;
   always @(posedge i2_0a) n_i2_up++;

   always @(negedge clk) begin
      if (rst_n && res_valid && res_ready) begin
         if (sb.size() == 0) chk("sb_unexpected_result", 1, 0);
         else begin
            logic [W:0] e;
            e = sb.pop_front();
            chk("res_data", 32'(res_data), 32'(e[W-1:0]));
            chk("res_err", 32'(res_err), 32'(e[W]));
         end
         n_res++;
      end
   end

   task automatic rdly();
      repeat ($urandom_range(1, 5)) @(posedge clk);
      #2;
   endtask

   // Behavioural core: pulls i1 (optionally twice) and i2, acks go, answers o.
   initial begin
      go_0a = 0; i1_0r = 0; i2_0r = 0; o_0a = 0; o_0d = '0;
      forever begin
         wait (go_0r === 1'b1);
         rdly();
         if (m_no_ack) wait (go_0r === 1'b0);
         else begin
            for (int k = 0; k < (m_double ? 2 : 1); k++) begin
               i1_0r = 1; wait (i1_0a === 1'b1);
               if (k == 0) cap_a = i1_0d;
               else        chk("i1_repull_data", 32'(i1_0d), 32'(cap_a));
               rdly(); i1_0r = 0; wait (i1_0a === 1'b0); rdly();
            end
            i2_0r = 1; wait (i2_0a === 1'b1); cap_b = i2_0d;
            rdly(); i2_0r = 0; wait (i2_0a === 1'b0); rdly();
            go_0a = 1;
            wait (o_0r === 1'b1); rdly();
            o_0d = cap_a + cap_b;
            #1 o_0a = 1;
            if (m_hold) begin
               wait (m_release); rdly();
               o_0a = 0; go_0a = 0;
            end else begin
               wait (o_0r === 1'b0); rdly(); o_0a = 0;
               wait (go_0r === 1'b0); rdly(); go_0a = 0;
            end
         end
      end
   end

   task automatic wait_op_ready(output int n);
      n = 0;
      while (op_ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
      chk("op_ready_timeout", 32'(op_ready), 1);
   endtask

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic e_err, input logic [W-1:0] e_data);
      int n;
      wait_op_ready(n);
      op_a = a; op_b = b; op_valid = 1;
      sb.push_back({e_err, e_data});
      @(negedge clk);
      op_valid = 0;
      chk("busy_after_accept", 32'(op_ready), 0);
   endtask

   task automatic wait_res_count(input int target);
      int n = 0;
      while (n_res < target && n < 400) begin @(posedge clk); n++; end
      chk("result_timeout", n_res, target);
      @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ctl"}, {24'd0, op_ready, res_valid, res_err, go_0r, o_0r, i1_0a, i2_0a, 1'b0}, 0);
      chk({tag, "_data"}, {8'd0, res_data, i1_0d, i2_0d}, 0);
   endtask

   initial begin
      int n, bad;
      rst_n = 0; op_valid = 0; op_a = '0; op_b = '0; res_ready = 0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1;
      wait_op_ready(n);

      // basic add with one four-phase cycle on each channel
      res_ready = 1;
      n_go_up = 0; n_o_up = 0; n_i1_up = 0; n_i2_up = 0;
      do_op(8'h12, 8'h34, 0, 8'h46);
      wait_res_count(1);
      chk("go_cycles", n_go_up, 1);
      chk("o_cycles", n_o_up, 1);
      chk("i1_cycles", n_i1_up, 1);
      chk("i2_cycles", n_i2_up, 1);
      chk("hs_rtz", {28'd0, go_0r, o_0r, i1_0a, i2_0a}, 0);

      // wrap-around sums, back to back
      do_op(8'hFF, 8'h01, 0, 8'h00);
      do_op(8'h80, 8'h80, 0, 8'h00);
      wait_res_count(3);

      // result held while host stalls
      res_ready = 0;
      do_op(8'h12, 8'h34, 0, 8'h46);
      n = 0;
      while (res_valid !== 1'b1 && n < 300) begin @(negedge clk); n++; end
      chk("hold_res_valid_seen", 32'(res_valid), 1);
      n_go_up = 0; n_o_up = 0; n_i1_up = 0; n_i2_up = 0;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (res_valid !== 1'b1 || res_data !== 8'h46 || op_ready !== 1'b0 ||
             go_0r !== 1'b0 || o_0r !== 1'b0 || i1_0a !== 1'b0 || i2_0a !== 1'b0) bad++;
      end
      chk("hold_stable_cycles_bad", bad, 0);
      chk("hold_no_toggles", n_go_up + n_o_up + n_i1_up + n_i2_up, 0);
      res_ready = 1;
      wait_res_count(4);

      // core never acks go: watchdog abort
      res_ready = 0;
      m_no_ack = 1;
      do_op(8'h55, 8'h66, 1, 8'h00);
      n = 0;
      while (go_0r !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      chk("tmo_go_up_seen", 32'(go_0r), 1);
      n = 0;
      while (res_valid !== 1'b1 && n < 1200) begin @(negedge clk); n++; end
      chk("tmo_cycles", n, 1023);
      chk("tmo_go_dropped", 32'(go_0r), 0);
      chk("tmo_err_flag", 32'(res_err), 1);
      m_no_ack = 0;
      res_ready = 1;
      wait_res_count(5);
      chk("tmo_recover_not_ready", 32'(op_ready), 0);
      @(negedge clk);
      chk("tmo_recover_to_idle", 32'(op_ready), 1);
      do_op(8'h05, 8'h03, 0, 8'h08);
      wait_res_count(6);

      // reset while in PULL with o_0a held high by the core
      res_ready = 0;
      m_hold = 1;
      do_op(8'h11, 8'h22, 0, 8'h33);
      n = 0;
      while (o_0a !== 1'b1 && n < 300) begin @(posedge clk); n++; end
      chk("pull_o_0a_seen", 32'(o_0a), 1);
      @(negedge clk); rst_n = 0;
      @(negedge clk);
      chk_all_zero("midreset");
      rst_n = 1;
      sb.delete();
      bad = 0;
      repeat (8) begin
         @(negedge clk);
         if (op_ready !== 1'b0) bad++;
      end
      chk("recover_waits_for_ack_low", bad, 0);
      m_release = 1;
      wait_op_ready(n);
      chk("recover_after_release", 32'(n > 2), 1);
      m_hold = 0; m_release = 0;

      // core pulls i1 twice in one activation
      res_ready = 1;
      m_double = 1;
      n_i1_up = 0; n_i2_up = 0;
      do_op(8'h3C, 8'h0F, 0, 8'h4B);
      n = 0; bad = 0;
      while (n_res < 7 && n < 400) begin
         @(posedge clk); #1;
         if (i1_0d !== 8'h3C) bad++;
         n++;
      end
      chk("double_result_timeout", n_res, 7);
      chk("double_i1_data_const", bad, 0);
      chk("double_i1_cycles", n_i1_up, 2);
      chk("double_i2_cycles", n_i2_up, 1);
      m_double = 0;
      repeat (5) @(negedge clk);
      chk("sb_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/balsa_bf_sync_driver.md
Name: balsa_bf_sync_driver

Overview:
- Clocked initiator/environment for the Balsa four-phase bundled-data adder core `Balsa_BF`, i.e. the other end of all of its channels.
- Activates `go`, answers the core's pull requests on `i1`/`i2` with held operand data, and pulls the result on `o`.
- Exposes a synchronous valid/ready operation port and result port, so clocked logic or the test harness can run adder transactions.
- All inbound handshake wires are synchronized; includes a watchdog for hung handshakes.

Parameters:
- WIDTH, 8, operand and result data width.
- SYNC_STAGES, 2, flops per inbound handshake synchronizer (minimum 2).
- SETUP_CYCLES, 1, cycles operand data is driven before `go_0r` rises (bundling margin).
- TIMEOUT_CYCLES, 1023, maximum cycles spent in any wait state before error.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- op_valid  in  1  host requests an add
- op_ready  out  1  driver accepts an operation
- op_a  in  WIDTH  operand A, driven on i1
- op_b  in  WIDTH  operand B, driven on i2
- res_valid  out  1  result available
- res_ready  in  1  host consumes the result
- res_data  out  WIDTH  captured `o_0d`
- res_err  out  1  transaction aborted by timeout
- go_0r  out  1  activation request
- go_0a  in  1  activation acknowledge (async)
- i1_0r  in  1  core pulls operand A (async)
- i1_0a  out  1  operand A acknowledge
- i1_0d  out  WIDTH  operand A data
- i2_0r  in  1  core pulls operand B (async)
- i2_0a  out  1  operand B acknowledge
- i2_0d  out  WIDTH  operand B data
- o_0r  out  1  result pull request
- o_0a  in  1  result acknowledge (async)
- o_0d  in  WIDTH  result data

Behaviour:

Clock and reset:
- Single clock `clk`.
- Reset `rst_n` is synchronous and active-low.
- While `rst_n`=0, all outputs are 0: op_ready, res_valid, res_data, res_err, go_0r, i1_0a, i1_0d, i2_0a, i2_0d, o_0r. Timeout counter is cleared. State becomes RECOVER.

Synchronizers:
- `go_0a`, `i1_0r`, `i2_0r` and `o_0a` each pass through SYNC_STAGES flops.
- Only the synced versions are used (`*_s`).
- `o_0d` is not synchronized. It is sampled only after `o_0a_s`=1, which the bundling constraint guarantees is stable.

FSM:
- RECOVER: all handshake outputs 0. Wait until `go_0a_s`, `o_0a_s`, `i1_0r_s` and `i2_0r_s` are all 0 for one cycle, then go to IDLE. This covers reset applied mid-handshake.
- IDLE: op_ready=1. On op_valid&op_ready, latch op_a into `i1_0d` and op_b into `i2_0d`, clear res_err, go to SETUP. Data is held constant until the next accept.
- SETUP: count SETUP_CYCLES, then go to GO_UP.
- GO_UP: go_0r=1. Wait for `go_0a_s`=1, then go to PULL.
- PULL: o_0r=1. On `o_0a_s`=1, capture `o_0d` into res_data, go to PULL_RTZ.
- PULL_RTZ: o_0r=0. Wait for `o_0a_s`=0, then go to GO_RTZ.
- GO_RTZ: go_0r=0. Wait for `go_0a_s`=0, then go to RESP.
- RESP: res_valid=1. On res_ready, go to IDLE.
- op_ready is 1 only in IDLE. res_valid is 1 only in RESP.

Operand responders (concurrent with the FSM):
- `i1_0a` = registered `i1_0r_s`, enabled only in SETUP through GO_RTZ; otherwise 0. `i2_0a` behaves the same way from `i2_0r_s`.
- This gives return-to-zero per request. Repeated pulls within one activation are each answered with the same held data.

Timeout:
- The counter resets on every state change.
- If a wait state (GO_UP, PULL, PULL_RTZ, GO_RTZ, RECOVER) reaches TIMEOUT_CYCLES:
  - set res_err=1 and res_data=0;
  - drive go_0r=o_0r=i1_0a=i2_0a=0;
  - go to RESP, then to RECOVER instead of IDLE after res_ready.
- A timeout in RECOVER only restarts the counter; no result is produced.

Arithmetic:
- The driver performs none; res_data is the core's WIDTH-bit sum, and carry-out is discarded by the core.

Simultaneous events:
- res_ready held high during entry to RESP consumes the result in that first RESP cycle.
- op_valid is ignored outside IDLE.
- Reset has priority over everything.

Decomposition:
- Package `balsa_hs_pkg`: FSM state encoding (RECOVER, IDLE, SETUP, GO_UP, PULL, PULL_RTZ, GO_RTZ, RESP) and the timeout counter width function clog2(TIMEOUT_CYCLES+1).
- One sub-module, `balsa_sync_bit` (parameter STAGES; clk, rst_n, d, q; reset value 0), instantiated four times.

Test Plan:
- Behavioural `Balsa_BF` model with random 1–5 cycle asynchronous delays; op_a=0x12, op_b=0x34 -> res_data=0x46, res_err=0. go_0r, o_0r, i1_0a and i2_0a each complete exactly one full four-phase cycle.
- op_a=0xFF, op_b=0x01 -> res_data=0x00 (wrap); then op_a=0x80, op_b=0x80 back-to-back -> 0x00. op_ready low from accept until the previous result is consumed.
- res_ready held 0 for 20 cycles in RESP -> res_valid and res_data=0x46 stable, op_ready=0, no handshake output toggles.
- Model never raises go_0a -> after 1023 cycles in GO_UP, res_valid=1, res_err=1, res_data=0, go_0r=0. After res_ready the FSM passes through RECOVER, and the next 0x05+0x03 gives 0x08.
- rst_n=0 for one cycle while in PULL, with o_0a still high in the model -> all outputs 0 next cycle, op_ready stays 0 until `o_0a_s` and `go_0a_s` are low, then goes 1.
- The core pulls i1 twice in one activation -> two i1_0a return-to-zero cycles, i1_0d=op_a constant throughout.
